// File: rtl/rgb_to_colour.sv
// rtl/rgb_to_colour.sv - classify an {R,G,B} word to the nearest of 8 primary/secondary colours
// Sequential search over the table, one entry per clock, valid/ready on both sides.
module rgb_to_colour #(
    parameter int CH_W          = 8,
    parameter bit SKIP_ON_EXACT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*CH_W-1:0]   rgb_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          colour,
    output logic                exact,
    output logic [CH_W+1:0]     distance
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic [CH_W-1:0] MAX = '1;

    state_t              r_state;
    state_t              w_next;
    logic [3*CH_W-1:0]   r_rgb;
    logic [2:0]          r_idx;
    logic [CH_W+1:0]     r_best_dist;
    logic [2:0]          r_best_code;
    logic [2:0]          r_colour;
    logic [CH_W+1:0]     r_distance;
    logic                r_exact;

    logic [CH_W+1:0]     w_dist;
    logic                w_better;
    logic [CH_W+1:0]     w_cand_dist;
    logic [2:0]          w_cand_code;
    logic                w_hit;
    logic                w_last;

    // Table channels are only 0 or MAX, so |v - t| needs no subtractor sign handling.
    function automatic logic [CH_W-1:0] chan_dist(input logic [CH_W-1:0] v, input logic hi);
        return hi ? (MAX - v) : v;
    endfunction

    assign w_dist = {2'b00, chan_dist(r_rgb[3*CH_W-1:2*CH_W], r_idx[2])}
                  + {2'b00, chan_dist(r_rgb[2*CH_W-1:CH_W],   r_idx[1])}
                  + {2'b00, chan_dist(r_rgb[CH_W-1:0],        r_idx[0])};

    // Strict compare keeps the lowest code on a tie.
    assign w_better    = (w_dist < r_best_dist);
    assign w_cand_dist = w_better ? w_dist : r_best_dist;
    assign w_cand_code = w_better ? r_idx  : r_best_code;
    assign w_hit       = SKIP_ON_EXACT && (w_dist == '0);
    assign w_last      = (r_idx == 3'd7) || w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SEARCH;
            end
            S_SEARCH: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb       <= '0;
            r_idx       <= '0;
            r_best_dist <= '0;
            r_best_code <= '0;
            r_colour    <= '0;
            r_distance  <= '0;
            r_exact     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rgb       <= rgb_in;
                        r_idx       <= '0;
                        r_best_dist <= '1;
                        r_best_code <= '0;
                    end
                end
                S_SEARCH: begin
                    r_idx       <= r_idx + 3'd1;
                    r_best_dist <= w_cand_dist;
                    r_best_code <= w_cand_code;
                    if (w_last) begin
                        r_colour   <= w_cand_code;
                        r_distance <= w_cand_dist;
                        r_exact    <= (w_cand_dist == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign colour   = r_colour;
    assign exact    = r_exact;
    assign distance = r_distance;

endmodule
